// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, LSU and memory-bus signals shared by the arbiter and its surroundings.
// master is the arbiter's view; slave is the view of the fetch/LSU stages and memory model.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_ack, mem_rdata,
        output if_done, if_rdata, if_err, ls_done, ls_rdata, ls_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall
    );
    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata, mem_ack, mem_rdata,
        input  if_done, if_rdata, if_err, ls_done, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and LSU, LSU first, with
// byte-lane generation, misalignment detection and a bus timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t          state;
    logic            own_ls;
    logic [CW-1:0]   cnt;
    logic            ls_ok;
    logic            if_ok;
    logic [3:0]      ls_be;
    logic [31:0]     ls_wd;
    always_comb begin
        ls_ok = (bus.ls_size == 2'd0) | (bus.ls_size == 2'd1 & ~bus.ls_addr[0]) |
                (bus.ls_size == 2'd2 & bus.ls_addr[1:0] == 2'b00);
        if_ok = bus.if_addr[1:0] == 2'b00;
        ls_be = bus.ls_size == 2'd0 ? 4'b0001 << bus.ls_addr[1:0] :
                bus.ls_size == 2'd1 ? 4'b0011 << bus.ls_addr[1:0] : 4'hF;
        ls_wd = bus.ls_size == 2'd0 ? {4{bus.ls_wdata[7:0]}} :
                bus.ls_size == 2'd1 ? {2{bus.ls_wdata[15:0]}} : bus.ls_wdata;
    end
    assign bus.stall = (bus.if_req | bus.ls_req) & ~(bus.if_done | bus.ls_done);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            own_ls        <= 1'b0;
            cnt           <= '0;
            bus.if_done   <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_err    <= 1'b0;
            bus.ls_done   <= 1'b0;
            bus.ls_rdata  <= '0;
            bus.ls_err    <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ls_req) begin
                        own_ls        <= 1'b1;
                        bus.mem_we    <= bus.ls_we;
                        bus.mem_addr  <= {bus.ls_addr[31:2], 2'b00};
                        bus.mem_be    <= ls_be;
                        bus.mem_wdata <= ls_wd;
                        cnt           <= '0;
                        bus.mem_req   <= ls_ok;
                        bus.ls_done   <= ~ls_ok;
                        bus.ls_err    <= ~ls_ok;
                        state         <= ls_ok ? BUS : RESP;
                    end else if (bus.if_req) begin
                        own_ls        <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= {bus.if_addr[31:2], 2'b00};
                        bus.mem_be    <= 4'hF;
                        bus.mem_wdata <= '0;
                        cnt           <= '0;
                        bus.mem_req   <= if_ok;
                        bus.if_done   <= ~if_ok;
                        bus.if_err    <= ~if_ok;
                        state         <= if_ok ? BUS : RESP;
                    end
                end
                BUS: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        state       <= RESP;
                        if (own_ls) begin
                            bus.ls_rdata <= bus.mem_rdata;
                            bus.ls_done  <= 1'b1;
                            bus.ls_err   <= 1'b0;
                        end else begin
                            bus.if_rdata <= bus.mem_rdata;
                            bus.if_done  <= 1'b1;
                            bus.if_err   <= 1'b0;
                        end
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        // abort: the rdata register keeps whatever it held before
                        bus.mem_req <= 1'b0;
                        cnt         <= CW'(TIMEOUT);
                        state       <= RESP;
                        bus.ls_done <= own_ls;
                        bus.ls_err  <= own_ls;
                        bus.if_done <= ~own_ls;
                        bus.if_err  <= ~own_ls;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    bus.if_done <= 1'b0;
                    bus.ls_done <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with hand-computed expectations for mem_arbiter (TIMEOUT = 4).
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int req_cycles;
    int done_at;
    logic err_at;
    logic [31:0] rdata_at;
    mem_arbiter_if bus();
    mem_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic ls_set(input logic we, input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        bus.ls_req = 1'b1;
        bus.ls_we = we;
        bus.ls_size = size;
        bus.ls_addr = addr;
        bus.ls_wdata = wdata;
    endtask
    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0; bus.ls_size = 0;
        bus.ls_addr = 0; bus.ls_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        #3;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_if_done", bus.if_done, 0);
        chk("rst_mem_be", bus.mem_be, 0);
        chk("rst_if_rdata", bus.if_rdata, 0);
        tick(); tick();
        rst_n = 1'b1;
        // fetch 0x100, zero-wait ack
        bus.if_req = 1; bus.if_addr = 32'h100;
        tick();
        chk("f1_req", bus.mem_req, 1);
        chk("f1_addr", bus.mem_addr, 32'h100);
        chk("f1_be", bus.mem_be, 4'hF);
        chk("f1_we", bus.mem_we, 0);
        chk("f1_stall", bus.stall, 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'h00500093;
        tick();
        bus.mem_ack = 0;
        chk("f1_done", bus.if_done, 1);
        chk("f1_rdata", bus.if_rdata, 32'h00500093);
        chk("f1_err", bus.if_err, 0);
        chk("f1_req_drop", bus.mem_req, 0);
        chk("f1_stall_done", bus.stall, 0);
        bus.if_req = 0;
        tick();
        chk("f1_done_pulse", bus.if_done, 0);
        // simultaneous IF 0x8 and LS store byte 0xA5 at 0x203
        bus.if_req = 1; bus.if_addr = 32'h8;
        ls_set(1, 2'd0, 32'h203, 32'h000000A5);
        tick();
        chk("s_req", bus.mem_req, 1);
        chk("s_addr", bus.mem_addr, 32'h200);
        chk("s_be", bus.mem_be, 4'b1000);
        chk("s_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        chk("s_we", bus.mem_we, 1);
        chk("s_stall", bus.stall, 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        bus.mem_ack = 0;
        chk("s_ls_done", bus.ls_done, 1);
        chk("s_if_not_done", bus.if_done, 0);
        bus.ls_req = 0;
        tick();
        chk("s_idle_req", bus.mem_req, 0);
        chk("s_idle_stall", bus.stall, 1);
        tick();
        chk("s_f_req", bus.mem_req, 1);
        chk("s_f_addr", bus.mem_addr, 32'h8);
        chk("s_f_we", bus.mem_we, 0);
        chk("s_f_stall", bus.stall, 1);
        bus.mem_ack = 1; bus.mem_rdata = 32'h12345678;
        tick();
        bus.mem_ack = 0;
        chk("s_if_done", bus.if_done, 1);
        chk("s_if_rdata", bus.if_rdata, 32'h12345678);
        chk("s_ls_idle", bus.ls_done, 0);
        bus.if_req = 0;
        tick();
        // misaligned half, then size 3
        ls_set(0, 2'd1, 32'h1001, 0);
        tick();
        chk("mh_done", bus.ls_done, 1);
        chk("mh_err", bus.ls_err, 1);
        chk("mh_req", bus.mem_req, 0);
        bus.ls_req = 0;
        tick();
        chk("mh_req2", bus.mem_req, 0);
        chk("mh_done_pulse", bus.ls_done, 0);
        ls_set(0, 2'd3, 32'h1000, 0);
        tick();
        chk("m3_done", bus.ls_done, 1);
        chk("m3_err", bus.ls_err, 1);
        chk("m3_req", bus.mem_req, 0);
        bus.ls_req = 0;
        tick();
        // timeout on fetch, no ack
        bus.if_req = 1; bus.if_addr = 32'h40;
        req_cycles = 0; done_at = 0; err_at = 0; rdata_at = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.mem_req) req_cycles++;
            if (bus.if_done) begin
                done_at = k; err_at = bus.if_err; rdata_at = bus.if_rdata;
                bus.if_req = 0;
            end
        end
        bus.if_req = 0;
        chk("to_req_cycles", req_cycles, 4);
        chk("to_done_at", done_at, 5);
        chk("to_err", err_at, 1);
        chk("to_rdata_kept", rdata_at, 32'h12345678);
        // LS load word with 3 wait states
        ls_set(0, 2'd2, 32'h300, 0);
        tick(); tick(); tick(); tick();
        chk("w_req_held", bus.mem_req, 1);
        chk("w_not_done", bus.ls_done, 0);
        bus.mem_ack = 1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_ack = 0;
        chk("w_done", bus.ls_done, 1);
        chk("w_rdata", bus.ls_rdata, 32'hCAFEF00D);
        chk("w_err", bus.ls_err, 0);
        bus.ls_req = 0;
        tick();
        // reset mid-BUS
        bus.if_req = 1; bus.if_addr = 32'h500;
        tick();
        chk("r_req_before", bus.mem_req, 1);
        bus.if_req = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("r_req", bus.mem_req, 0);
        chk("r_addr", bus.mem_addr, 0);
        chk("r_be", bus.mem_be, 0);
        chk("r_ls_rdata", bus.ls_rdata, 0);
        bus.mem_ack = 1; bus.mem_rdata = 32'h77777777;
        tick();
        chk("r_ack_ignored", bus.if_done, 0);
        #1 rst_n = 1'b1;
        tick();
        chk("r_idle_ack_done", bus.if_done, 0);
        chk("r_idle_ack_rdata", bus.if_rdata, 0);
        chk("r_idle_ack_ls", bus.ls_rdata, 0);
        bus.mem_ack = 0;
        bus.if_req = 1; bus.if_addr = 32'h10;
        tick();
        chk("r2_req", bus.mem_req, 1);
        chk("r2_addr", bus.mem_addr, 32'h10);
        bus.mem_ack = 1; bus.mem_rdata = 32'h0000ABCD;
        tick();
        bus.mem_ack = 0;
        bus.if_req = 0;
        chk("r2_done", bus.if_done, 1);
        chk("r2_rdata", bus.if_rdata, 32'h0000ABCD);
        chk("r2_err", bus.if_err, 0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
